// File: rtl/stopwatch_if.sv
// Stopwatch control bundle: raw front-panel buttons and the digit-chain
// status in, count/clear strobes and display data out.
//   btn_start/stop/lap/clear : raw asynchronous buttons, active-high
//   live_bcd                 : current digit-chain value {d3,d2,d1,d0}
//   wrap_in                  : digit-3 carry-out (9999 -> 0000)
//   count_en / count_clr     : one-cycle strobes to the digit chain
//   disp_bcd                 : value for the seven-segment scan logic
//   running/lap_active/overflow : state flags
// master drives the buttons and chain status; slave is the controller.
interface stopwatch_if;
  logic        btn_start;
  logic        btn_stop;
  logic        btn_lap;
  logic        btn_clear;
  logic [15:0] live_bcd;
  logic        wrap_in;
  logic        count_en;
  logic        count_clr;
  logic [15:0] disp_bcd;
  logic        running;
  logic        lap_active;
  logic        overflow;

  modport master (
    output btn_start, btn_stop, btn_lap, btn_clear, live_bcd, wrap_in,
    input  count_en, count_clr, disp_bcd, running, lap_active, overflow
  );

  modport slave (
    input  btn_start, btn_stop, btn_lap, btn_clear, live_bcd, wrap_in,
    output count_en, count_clr, disp_bcd, running, lap_active, overflow
  );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control sequencer. Synchronises and debounces the four buttons,
// runs the IDLE/RUN/LAP/PAUSE/HALT state machine, divides clk down to the
// 1 ms count_en strobe, keeps the lap snapshot and picks the displayed value.
//   clk   : system clock
//   reset : synchronous, active-high
//   sw    : stopwatch_if.slave (buttons, live_bcd, wrap_in in; strobes,
//           disp_bcd and state flags out)
module stopwatch_ctrl #(
  parameter int TICK_DIV        = 50000,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic       clk,
  input  logic       reset,
  stopwatch_if.slave sw
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DB_LAST    = DW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_LAP, S_PAUSE, S_HALT} state_t;

  // Button index: 0 start, 1 stop, 2 lap, 3 clear
  logic [3:0]    btn_raw;
  logic [3:0]    sync_p0;
  logic [3:0]    sync_p1;
  logic [3:0]    db_lvl;
  logic [3:0]    db_lvl_q;
  logic [3:0]    press;
  logic [DW-1:0] db_cnt [4];

  logic ev_clear, ev_stop, ev_start, ev_lap;

  state_t        state, state_nxt;
  logic          lap_capture;
  logic          counting, counting_nxt, tick_go;
  logic [PW-1:0] presc;
  logic [15:0]   lap_reg;
  logic          count_en_q;
  logic          count_clr_q;
  logic [15:0]   disp_q;

  assign btn_raw = {sw.btn_clear, sw.btn_lap, sw.btn_stop, sw.btn_start};

  // Stage p0/p1: two-flop synchroniser; then debounce on the p1 sample
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_p0  <= '0;
      sync_p1  <= '0;
      db_lvl   <= '0;
      db_lvl_q <= '0;
      for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
    end else begin
      sync_p0  <= btn_raw;
      sync_p1  <= sync_p0;
      db_lvl_q <= db_lvl;
      for (int i = 0; i < 4; i++) begin
        if (sync_p1[i] == db_lvl[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          // this is the Nth consecutive differing sample
          db_cnt[i] <= '0;
          db_lvl[i] <= sync_p1[i];
        end else begin
          db_cnt[i] <= db_cnt[i] + DW'(1);
        end
      end
    end
  end

  // Rising edge of the debounced level only; releases are not events
  assign press = db_lvl & ~db_lvl_q;

  // Only the highest-priority coincident press survives
  assign ev_clear = press[3];
  assign ev_stop  = press[1] & ~press[3];
  assign ev_start = press[0] & ~press[3] & ~press[1];
  assign ev_lap   = press[2] & ~press[3] & ~press[1] & ~press[0];

  always_comb begin
    state_nxt   = state;
    lap_capture = 1'b0;
    case (state)
      S_IDLE: begin
        if (ev_start) state_nxt = S_RUN;
      end
      S_RUN: begin
        if (ev_clear)        state_nxt = S_IDLE;
        else if (sw.wrap_in) state_nxt = S_HALT;
        else if (ev_stop)    state_nxt = S_PAUSE;
        else if (ev_lap) begin
          state_nxt   = S_LAP;
          lap_capture = 1'b1;
        end
      end
      S_LAP: begin
        if (ev_clear)        state_nxt = S_IDLE;
        else if (sw.wrap_in) state_nxt = S_HALT;
        else if (ev_stop)    state_nxt = S_PAUSE;
        else if (ev_lap)     state_nxt = S_RUN;
      end
      S_PAUSE: begin
        if (ev_clear)      state_nxt = S_IDLE;
        else if (ev_start) state_nxt = S_RUN;
      end
      S_HALT: begin
        if (ev_clear) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // The prescaler only advances on cycles that stay in RUN/LAP, so a stop
  // freezes it at the elapsed fraction and a resume finishes that millisecond.
  assign counting     = (state == S_RUN) || (state == S_LAP);
  assign counting_nxt = (state_nxt == S_RUN) || (state_nxt == S_LAP);
  assign tick_go      = counting && counting_nxt;

  // Stage p2: state, prescaler, lap snapshot and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      presc       <= '0;
      lap_reg     <= '0;
      count_en_q  <= 1'b0;
      count_clr_q <= 1'b0;
      disp_q      <= '0;
    end else begin
      state       <= state_nxt;
      count_clr_q <= ev_clear;
      count_en_q  <= tick_go && (presc == PRESC_LAST);
      if (tick_go) begin
        presc <= (presc == PRESC_LAST) ? '0 : presc + PW'(1);
      end else if ((state == S_IDLE) || (state == S_HALT)) begin
        presc <= '0;
      end
      if (lap_capture) lap_reg <= sw.live_bcd;
      disp_q <= (state == S_LAP) ? lap_reg : sw.live_bcd;
    end
  end

  assign sw.count_en   = count_en_q;
  assign sw.count_clr  = count_clr_q;
  assign sw.disp_bcd   = disp_q;
  assign sw.running    = counting;
  assign sw.lap_active = (state == S_LAP);
  assign sw.overflow   = (state == S_HALT);

endmodule
